// File: rtl/and_seq_recognizer_if.sv
// Operand/handshake bundle between the AND-stage front end and the sequence recognizer.
// The master drives the samples and clear. The slave returns the pulse, count and sat flag.
interface and_seq_recognizer_if #(
   parameter int COUNT_W = 8
);
   logic               valid;
   logic               x1;
   logic               x0;
   logic               clear;
   logic               z;
   logic [COUNT_W-1:0] count;
   logic               sat;

   modport master (
      output valid, x1, x0, clear,
      input  z, count, sat
   );

   modport slave (
      input  valid, x1, x0, clear,
      output z, count, sat
   );
endinterface

// File: rtl/and_seq_recognizer.sv
// Detects the valid-qualified operand sequence 00 -> 01 -> 11 and pulses z for one cycle.
// It also keeps a saturating detection count with a registered saturation flag.
module and_seq_recognizer #(
   parameter int COUNT_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   and_seq_recognizer_if.slave   bus
);

   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic               r_z;
   logic               r_sat;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] w_count_inc;
   logic [1:0]         w_sample;
   logic               w_detect;

   assign w_sample    = {bus.x1, bus.x0};
   assign w_detect    = (r_state == S2) && bus.valid && (w_sample == 2'b11);
   assign w_count_inc = r_count + CNT_ONE;

   always_comb begin
      // NOTE: default first so every path assigns w_next_state and no latch is inferred.
      w_next_state = S0;
      case (r_state)
         S0: w_next_state = (bus.valid && w_sample == 2'b00) ? S1 : S0;
         S1: begin
            if (!bus.valid)               w_next_state = S1;
            else if (w_sample == 2'b00)   w_next_state = S1;
            else if (w_sample == 2'b01)   w_next_state = S2;
            else                          w_next_state = S0;
         end
         S2: begin
            if (!bus.valid)               w_next_state = S2;
            else if (w_sample == 2'b00)   w_next_state = S1;
            else                          w_next_state = S0;
         end
         default: w_next_state = S0;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S0;
         r_z     <= 1'b0;
         r_count <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_z     <= w_detect;
         // Clear outranks a simultaneous detection; the pulse above is unaffected.
         if (bus.clear) begin
            r_count <= '0;
            r_sat   <= 1'b0;
         end else if (w_detect && (r_count != CNT_MAX)) begin
            r_count <= w_count_inc;
            r_sat   <= (w_count_inc == CNT_MAX);
         end
      end
   end

   assign bus.z     = r_z;
   assign bus.count = r_count;
   assign bus.sat   = r_sat;

endmodule

// File: tb/tb_and_seq_recognizer.sv
// Directed bench for and_seq_recognizer with a sample-history model checked every cycle.
// Literal expectations pin the model at the key points of each scenario.
module tb_and_seq_recognizer;

   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   bit   run   = 1'b0;

   and_seq_recognizer_if #(.COUNT_W(CW)) bus ();

   and_seq_recognizer #(.COUNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Model: detection when the two previous valid samples since reset were 00 then 01
   // and the current valid sample is 11. Bit 2 set marks an empty history slot.
   logic [2:0] h_old, h_new;
   int         m_count;
   bit         m_z;
   bit         det;

   always @(posedge clock) begin
      if (reset) begin
         h_old   = 3'b100;
         h_new   = 3'b100;
         m_z     = 1'b0;
         m_count = 0;
      end else begin
         det = bus.valid && h_old == 3'b000 && h_new == 3'b001 && {bus.x1, bus.x0} == 2'b11;
         if (bus.valid) begin
            h_old = h_new;
            h_new = {1'b0, bus.x1, bus.x0};
         end
         m_z = det;
         if (bus.clear)                   m_count = 0;
         else if (det && m_count < MAXC)  m_count = m_count + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (run) begin
         check("cyc_z",     int'(bus.z),     int'(m_z));
         check("cyc_count", int'(bus.count), m_count);
         check("cyc_sat",   int'(bus.sat),   int'(m_count == MAXC));
      end
   end

   task automatic step(input logic v, input logic [1:0] s);
      bus.valid = v;
      {bus.x1, bus.x0} = s;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      bus.valid = 1'b0;
      bus.clear = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic seq_ok();
      step(1'b1, 2'b00);
      step(1'b1, 2'b01);
      step(1'b1, 2'b11);
   endtask

   initial begin
      bus.valid = 1'b0;
      bus.x1    = 1'b0;
      bus.x0    = 1'b0;
      bus.clear = 1'b0;

      // Basic detection straight after reset
      do_reset();
      run = 1'b1;
      check("rst_z", int'(bus.z), 0);
      check("rst_count", int'(bus.count), 0);
      check("rst_sat", int'(bus.sat), 0);
      step(1'b1, 2'b00);
      step(1'b1, 2'b01);
      check("pre_det_z", int'(bus.z), 0);
      step(1'b1, 2'b11);
      check("det1_z", int'(bus.z), 1);
      check("det1_count", int'(bus.count), 1);
      check("det1_sat", int'(bus.sat), 0);
      step(1'b0, 2'b00);
      check("det1_z_one_cycle", int'(bus.z), 0);

      // Broken sequence, then repeated 00 keeping the prefix
      do_reset();
      step(1'b1, 2'b00);
      step(1'b1, 2'b01);
      step(1'b1, 2'b10);
      step(1'b1, 2'b11);
      check("broken_z", int'(bus.z), 0);
      check("broken_count", int'(bus.count), 0);
      step(1'b1, 2'b00);
      step(1'b1, 2'b00);
      step(1'b1, 2'b01);
      step(1'b1, 2'b11);
      check("rep00_z", int'(bus.z), 1);
      check("rep00_count", int'(bus.count), 1);

      // Invalid gaps carrying 11 must neither detect nor disturb the prefix
      do_reset();
      step(1'b1, 2'b00);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 2'b11);
         check("gap_z", int'(bus.z), 0);
      end
      step(1'b1, 2'b01);
      step(1'b1, 2'b11);
      check("gap_det_z", int'(bus.z), 1);
      check("gap_det_count", int'(bus.count), 1);

      // Saturation at 3 with a 2-bit counter
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         seq_ok();
         check("sat_seq_z", int'(bus.z), 1);
         check("sat_seq_count", int'(bus.count), (i < 3) ? i : 3);
         check("sat_seq_sat", int'(bus.sat), (i >= 3) ? 1 : 0);
      end
      bus.clear = 1'b1;
      step(1'b0, 2'b00);
      bus.clear = 1'b0;
      check("clr_sat_count", int'(bus.count), 0);
      check("clr_sat_sat", int'(bus.sat), 0);

      // Clear on the detecting edge wins over the increment; the pulse survives
      do_reset();
      seq_ok();
      seq_ok();
      check("pre_clr_count", int'(bus.count), 2);
      step(1'b1, 2'b00);
      step(1'b1, 2'b01);
      bus.clear = 1'b1;
      step(1'b1, 2'b11);
      bus.clear = 1'b0;
      check("clr_det_z", int'(bus.z), 1);
      check("clr_det_count", int'(bus.count), 0);
      check("clr_det_sat", int'(bus.sat), 0);
      seq_ok();
      check("post_clr_count", int'(bus.count), 1);

      // Reset while in S2 discards the prefix
      do_reset();
      step(1'b1, 2'b00);
      step(1'b1, 2'b01);
      do_reset();
      step(1'b1, 2'b11);
      check("rst_s2_z", int'(bus.z), 0);
      check("rst_s2_count", int'(bus.count), 0);
      seq_ok();
      check("rst_s2_redo_z", int'(bus.z), 1);
      check("rst_s2_redo_count", int'(bus.count), 1);

      step(1'b0, 2'b00);
      step(1'b0, 2'b00);
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
